// File: rtl/mips_pkg.sv
// Shared encodings and helpers for the MIPS instruction-fetch slice.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  // Fetch-unit FSM state encodings
  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  // Next-PC source select encodings
  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Sign-extended, word-scaled branch displacement from a 16-bit immediate
  function automatic logic [XLEN-1:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/mips_next_pc.sv
// Combinational next-PC selection: jump beats taken branch beats sequential.
module mips_next_pc
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instr,
  input  logic            Jump,
  input  logic            Branch,
  input  logic            Zero_flag,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc,
  output logic [1:0]      npc_sel
);

  // Opcode bits are decoded by the control unit, not needed here
  logic unused_opcode;
  assign unused_opcode = ^instr[31:26];

  // Select the PC source and form the target address
  always_comb begin
    pc_plus4 = pc + 32'd4;
    npc_sel  = NPC_SEQ;
    if (Jump) begin
      npc_sel = NPC_J;
    end else if (Branch && Zero_flag) begin
      npc_sel = NPC_BR;
    end
    case (npc_sel)
      NPC_J:   next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      NPC_BR:  next_pc = pc_plus4 + br_offset(instr[15:0]);
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over req/rdy, presents one
// instruction per execute cycle and halts on an out-of-range next PC.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned     IMEM_DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rdy,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  input  logic            Jump,
  input  logic            Branch,
  input  logic            Zero_flag,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            addr_err
);

  // One past the last legal byte address; 33 bits so a full 4 GiB map fits
  localparam logic [XLEN:0] PC_LIMIT = 33'(IMEM_DEPTH) << 2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            addr_err_q, addr_err_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;

  logic [XLEN-1:0] next_pc;
  logic [1:0]      npc_sel;
  logic            out_of_range;

  mips_next_pc u_next_pc (
    .pc        (pc_q),
    .instr     (instr_q),
    .Jump      (Jump),
    .Branch    (Branch),
    .Zero_flag (Zero_flag),
    .pc_plus4  (pc_plus4),
    .next_pc   (next_pc),
    .npc_sel   (npc_sel)
  );

  // Select encoding is informational at this level
  logic unused_npc_sel;
  assign unused_npc_sel = ^npc_sel;

  assign out_of_range = ({1'b0, next_pc} >= PC_LIMIT);

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      addr_err_q <= 1'b0;
      req_q      <= 1'b1;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      addr_err_q <= addr_err_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state and next-register values
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    addr_err_d = addr_err_q;
    case (state_q)
      FETCH: begin
        if (imem_rdy) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        pc_d = next_pc;
        if (out_of_range) begin
          addr_err_d = 1'b1;
          state_d    = HALT;
        end else begin
          state_d = FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
    req_d   = (state_d == FETCH);
    valid_d = (state_d == EXEC);
  end

  // Request is suppressed combinationally for any cycle spent in reset
  assign imem_req    = req_q & rst_n;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: reference memory, control-unit
// stand-in, execute-stream scoreboard, next-PC vector table and corner cases.
module tb_mips_fetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_rdy;
  logic [31:0] imem_rdata;
  logic        Jump, Branch, Zero_flag;

  logic        imem_req, instr_valid, addr_err;
  logic [31:0] imem_addr, instr, pc, pc_plus4;

  logic        s_imem_req, s_instr_valid, s_addr_err;
  logic [31:0] s_imem_addr, s_instr, s_pc, s_pc_plus4;

  logic [31:0] mem [0:63];
  int          checks = 0;
  int          errors = 0;
  int          wait_cnt = 0;
  int          rdy_delay = 0;
  bit          rdy_en = 1'b0;
  bit          force_rdy = 1'b0;
  bit          force_br = 1'b0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exec_t;
  exec_t exp_q[$];

  typedef struct {
    string       name;
    logic [31:0] at;
    logic [31:0] ins;
    logic        z;
    logic        fb;
    logic [31:0] nxt;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  mips_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdy(imem_rdy), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .Jump(Jump), .Branch(Branch),
    .Zero_flag(Zero_flag), .pc(pc), .pc_plus4(pc_plus4), .addr_err(addr_err)
  );

  mips_fetch_unit #(.RESET_PC(32'h0), .IMEM_DEPTH(16)) dut_small (
    .clk(clk), .rst_n(rst_n), .imem_req(s_imem_req), .imem_addr(s_imem_addr),
    .imem_rdy(imem_rdy), .imem_rdata(imem_rdata), .instr(s_instr),
    .instr_valid(s_instr_valid), .Jump(Jump), .Branch(Branch),
    .Zero_flag(Zero_flag), .pc(s_pc), .pc_plus4(s_pc_plus4), .addr_err(s_addr_err)
  );

  // Memory and control-unit models (both DUTs run in lockstep from reset)
  assign imem_rdata = mem[imem_addr[7:2]];
  assign Jump       = (instr[31:26] == 6'd2);
  assign Branch     = (instr[31:26] == 6'd4) | force_br;
  assign imem_rdy   = force_rdy | (rdy_en & imem_req & (wait_cnt >= rdy_delay));

  // Count consecutive unanswered request cycles
  always @(posedge clk) wait_cnt <= (imem_req && !imem_rdy) ? wait_cnt + 1 : 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every executed instruction must match the next expected entry
  always @(negedge clk) begin
    if (instr_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_exec_pc", pc, 32'hFFFF_FFFF);
      end else begin
        exec_t e;
        e = exp_q.pop_front();
        check("exec_pc", pc, e.pc);
        check("exec_instr", instr, e.instr);
        check("exec_req_low", 32'(imem_req), 32'd0);
      end
    end
  end

  task automatic wait_exec(input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (instr_valid) return;
    end
    check(name, 32'd0, 32'd1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    Zero_flag = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 | 32'(i);
    mem[0] = 32'h2001_0001;
    mem[1] = 32'h2002_0002;
    mem[2] = 32'h2003_0003;
    mem[3] = 32'h2004_0004;

    vecs[0] = '{"beq_taken_back", 32'h10, 32'h1000_FFFC, 1'b1, 1'b0, 32'h04};
    vecs[1] = '{"beq_not_taken",  32'h10, 32'h1000_FFFC, 1'b0, 1'b0, 32'h14};
    vecs[2] = '{"jump",           32'h20, 32'h0800_0010, 1'b0, 1'b0, 32'h40};
    vecs[3] = '{"jump_over_br",   32'h20, 32'h0800_0010, 1'b1, 1'b1, 32'h40};
    vecs[4] = '{"sequential",     32'h08, 32'h2005_0005, 1'b1, 1'b0, 32'h0C};
    vecs[5] = '{"beq_fwd",        32'h30, 32'h1000_0004, 1'b1, 1'b0, 32'h44};

    // Reset state, then straight-line code with immediate rdy
    @(negedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);
    check("rst_small_pc_plus4", s_pc_plus4, 32'h4);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    for (int k = 0; k < 3; k++) exp_q.push_back('{32'(k * 4), mem[k]});
    rdy_en = 1'b1;
    rst_n = 1'b1;
    #1;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);
    for (int k = 0; k < 3; k++) begin
      wait_exec("timeout_straight");
      if (k == 2) rdy_en = 1'b0;
      @(negedge clk);
      check("straight_valid_gap", 32'(instr_valid), 32'd0);
      check("straight_next_addr", imem_addr, 32'((k + 1) * 4));
      check("straight_next_req", 32'(imem_req), 32'd1);
    end

    // Delayed rdy: request held stable, execute one cycle after rdy
    apply_reset();
    exp_q.push_back('{32'h0, mem[0]});
    exp_q.push_back('{32'h4, mem[1]});
    rdy_en = 1'b1;
    rdy_delay = 0;
    wait_exec("timeout_delay_first");
    rdy_delay = 3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("delay_req", 32'(imem_req), 32'd1);
      check("delay_addr", imem_addr, 32'h4);
      check("delay_valid", 32'(instr_valid), 32'd0);
    end
    @(negedge clk);
    check("delay_valid_after_rdy", 32'(instr_valid), 32'd1);
    rdy_en = 1'b0;
    rdy_delay = 0;

    // Next-PC vector table: jump from 0 to the vector PC, execute, check target
    foreach (vecs[v]) begin
      rdy_en = 1'b0;
      apply_reset();
      mem[0] = 32'h0800_0000 | (vecs[v].at >> 2);
      mem[vecs[v].at[7:2]] = vecs[v].ins;
      Zero_flag = vecs[v].z;
      force_br = vecs[v].fb;
      exp_q.push_back('{32'h0, mem[0]});
      exp_q.push_back('{vecs[v].at, vecs[v].ins});
      rdy_en = 1'b1;
      wait_exec("timeout_vec_jump");
      wait_exec("timeout_vec_instr");
      rdy_en = 1'b0;
      @(negedge clk);
      check({vecs[v].name, "_addr"}, imem_addr, vecs[v].nxt);
      check({vecs[v].name, "_req"}, 32'(imem_req), 32'd1);
    end
    force_br = 1'b0;

    // Out-of-range branch on the 16-word instance halts until reset
    rdy_en = 1'b0;
    apply_reset();
    mem[0] = 32'h1000_000F;
    Zero_flag = 1'b1;
    exp_q.push_back('{32'h0, mem[0]});
    rdy_en = 1'b1;
    wait_exec("timeout_err_branch");
    rdy_en = 1'b0;
    @(negedge clk);
    check("big_no_err", 32'(addr_err), 32'd0);
    check("big_addr_0x40", imem_addr, 32'h40);
    for (int i = 0; i < 3; i++) begin
      check("halt_err", 32'(s_addr_err), 32'd1);
      check("halt_req", 32'(s_imem_req), 32'd0);
      check("halt_pc", s_pc, 32'h40);
      check("halt_valid", 32'(s_instr_valid), 32'd0);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("halt_rst_req", 32'(s_imem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("halt_rst_pc", s_pc, 32'h0);
    check("halt_rst_err", 32'(s_addr_err), 32'd0);
    check("halt_resume_req", 32'(s_imem_req), 32'd1);
    check("halt_resume_addr", s_imem_addr, 32'h0);
    exp_q.push_back('{32'h0, mem[0]});
    rdy_en = 1'b1;
    wait_exec("timeout_resume");
    rdy_en = 1'b0;
    check("resume_small_valid", 32'(s_instr_valid), 32'd1);
    check("resume_small_instr", s_instr, mem[0]);
    Zero_flag = 1'b0;

    // Reset in FETCH with rdy in the same cycle: the fetch is discarded
    rdy_en = 1'b0;
    apply_reset();
    mem[0] = 32'h2001_0001;
    mem[1] = 32'h2002_0002;
    exp_q.push_back('{32'h0, mem[0]});
    rdy_en = 1'b1;
    wait_exec("timeout_midrst");
    rdy_en = 1'b0;
    @(negedge clk);
    check("midrst_fetch_addr", imem_addr, 32'h4);
    rst_n = 1'b0;
    force_rdy = 1'b1;
    @(negedge clk);
    check("midrst_instr", instr, 32'h0);
    check("midrst_valid", 32'(instr_valid), 32'd0);
    check("midrst_pc", pc, 32'h0);
    rst_n = 1'b1;
    force_rdy = 1'b0;
    #1;
    check("midrst_req", 32'(imem_req), 32'd1);
    check("midrst_addr", imem_addr, 32'h0);
    @(negedge clk);
    check("midrst_no_exec", 32'(instr_valid), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
